// File: rtl/bpsk_tx_framer_pkg.sv
// Shared definitions for the BPSK TX framer: sample type, symbol constants,
// FSM state encoding and the samples-per-symbol computation.
// Optional build macro BPSK_TX_DIFF_ENC_EN is consumed by bpsk_tx_framer.sv.
package bpsk_tx_framer_pkg;

    // Sample format: signed two's complement, SYMBOL_FRAC fractional bits.
    localparam int SYMBOL_WIDTH = 14;
    localparam int SYMBOL_FRAC  = 12;

    // Strobe and baud rates; their ratio must be an integer of at least 2.
    localparam int SAMPLE_RATE  = 6_000_000;
    localparam int SYMBOL_RATE  = 50_000;

    // Sync word: the low SYNC_LEN bits are sent MSB-first (SYNC_LEN in 1..32).
    localparam int          SYNC_LEN  = 32;
    localparam logic [31:0] SYNC_WORD = 32'hF3A0_5C6B;

    // Zero-valued symbol periods appended to flush the downstream RRC filter.
    localparam int TAIL_SYMS = 16;

    // Payload word size in bits (one AXI-Stream beat).
    localparam int WORD_BITS = 32;

    // Symbol index counter must hold the largest of SYNC_LEN, WORD_BITS, TAIL_SYMS.
    localparam int BCNT_W = 6;

    typedef logic signed [SYMBOL_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    function automatic int calc_sps(input int sample_rate, input int symbol_rate);
        return sample_rate / symbol_rate;
    endfunction

    localparam int SPS    = calc_sps(SAMPLE_RATE, SYMBOL_RATE);
    localparam int SCNT_W = $clog2(SPS);

    // +1.0 in the sample format.
    function automatic sample_t sym_one();
        return sample_t'(1 << SYMBOL_FRAC);
    endfunction

    // -1.0 in the sample format.
    function automatic sample_t sym_neg_one();
        return -sym_one();
    endfunction

    function automatic sample_t sym_zero();
        return '0;
    endfunction

endpackage

// File: rtl/bpsk_tx_framer_axis_word_hold.sv
// One-deep prefetch register between the AXI-Stream slave and the payload
// shift register. Accepts at most one word ahead of the word being sent and
// stops accepting once the word carrying tlast has been taken.
//
// Handshake: a word transfers on a clock edge where tvalid and tready are both
// high; tready never depends on tvalid, and tvalid/tdata/tlast are expected to
// stay stable until the transfer happens.
module bpsk_tx_framer_axis_word_hold
    import bpsk_tx_framer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 active,
    input  logic [WORD_BITS-1:0] tdata,
    input  logic                 tlast,
    input  logic                 tvalid,
    output logic                 tready,
    input  logic                 unload,
    output logic [WORD_BITS-1:0] hold_data,
    output logic                 hold_last,
    output logic                 hold_full
);

    logic last_taken;
    logic capture;

    // Ready only while a frame is transmitting, the slot is free and the
    // frame's final word has not yet been fetched; en low blocks transfers.
    assign tready  = en && active && !hold_full && !last_taken;
    assign capture = tvalid && tready;

    // Hold slot and end-of-frame tracking; an unload frees the slot before a
    // same-cycle capture refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            last_taken <= 1'b0;
        end else if (en) begin
            if (clear) begin
                hold_full  <= 1'b0;
                hold_last  <= 1'b0;
                last_taken <= 1'b0;
            end else begin
                if (capture) begin
                    hold_data <= tdata;
                    hold_last <= tlast;
                    if (tlast) begin
                        last_taken <= 1'b1;
                    end
                end
                hold_full <= capture || (hold_full && !unload);
            end
        end
    end

endmodule

// File: rtl/bpsk_tx_framer.sv
// BPSK transmit framer: prepends the sync word to AXI-Stream payload words,
// serializes MSB-first, maps bits to +/-1 and emits one impulse per symbol
// period (SPS strobes) followed by zero tail symbols.
// Build option: define BPSK_TX_DIFF_ENC_EN to differentially encode payload
// bits (sync always sent raw).
module bpsk_tx_framer
    import bpsk_tx_framer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 new_sample,
    input  logic [WORD_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output sample_t              sample,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    output state_t               state_dbg
);

    // Sync pattern left-justified so its first bit sits at the shift MSB.
    localparam logic [WORD_BITS-1:0] SYNC_ALIGNED = SYNC_WORD << (WORD_BITS - SYNC_LEN);
    localparam sample_t ONE     = sym_one();
    localparam sample_t NEG_ONE = sym_neg_one();
    localparam sample_t ZERO    = sym_zero();

    state_t               state;
    state_t               state_nxt;
    logic [SCNT_W-1:0]    sample_cnt;
    logic [BCNT_W-1:0]    bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic                 cur_last;

    logic                 frame_start;
    logic                 load_word;
    logic                 underrun_set;
    logic                 done_set;
    logic                 tick;
    logic                 wrap;
    logic                 last_sym;
    logic                 tx_bit;
    sample_t              sym_val;
    logic                 active;

    logic [WORD_BITS-1:0] hold_data;
    logic                 hold_last;
    logic                 hold_full;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign active    = (state == SYNC) || (state == DATA);
    assign tick      = en && new_sample && (state != IDLE);
    assign wrap      = tick && (sample_cnt == SCNT_W'(SPS - 1));

    bpsk_tx_framer_axis_word_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (frame_start),
        .active    (active),
        .tdata     (s_axis_tdata),
        .tlast     (s_axis_tlast),
        .tvalid    (s_axis_tvalid),
        .tready    (s_axis_tready),
        .unload    (load_word),
        .hold_data (hold_data),
        .hold_last (hold_last),
        .hold_full (hold_full)
    );

`ifdef BPSK_TX_DIFF_ENC_EN
    logic prev_bit;

    // Differential reference: the previously transmitted payload bit,
    // restarted at 0 for every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_bit <= 1'b0;
        end else if (en) begin
            if (frame_start) begin
                prev_bit <= 1'b0;
            end else if (wrap && (state == DATA)) begin
                prev_bit <= tx_bit;
            end
        end
    end

    assign tx_bit = shift_reg[WORD_BITS-1] ^ prev_bit;
`else
    assign tx_bit = shift_reg[WORD_BITS-1];
`endif

    // Current symbol value and end-of-segment detection for the active state.
    always_comb begin
        sym_val  = ZERO;
        last_sym = 1'b0;
        case (state)
            SYNC: begin
                sym_val  = shift_reg[WORD_BITS-1] ? ONE : NEG_ONE;
                last_sym = (bit_cnt == BCNT_W'(SYNC_LEN - 1));
            end
            DATA: begin
                sym_val  = tx_bit ? ONE : NEG_ONE;
                last_sym = (bit_cnt == BCNT_W'(WORD_BITS - 1));
            end
            TAIL: begin
                sym_val  = ZERO;
                last_sym = (bit_cnt == BCNT_W'(TAIL_SYMS - 1));
            end
            default: begin
                sym_val  = ZERO;
                last_sym = 1'b0;
            end
        endcase
    end

    // Next-state logic; segment transitions happen only as the last symbol
    // of a segment ends (sample counter wrapping).
    always_comb begin
        state_nxt    = state;
        frame_start  = 1'b0;
        load_word    = 1'b0;
        underrun_set = 1'b0;
        done_set     = 1'b0;
        case (state)
            IDLE: begin
                if (en && start && s_axis_tvalid) begin
                    state_nxt   = SYNC;
                    frame_start = 1'b1;
                end
            end
            SYNC: begin
                if (wrap && last_sym) begin
                    if (hold_full) begin
                        state_nxt = DATA;
                        load_word = 1'b1;
                    end else begin
                        state_nxt    = TAIL;
                        underrun_set = 1'b1;
                    end
                end
            end
            DATA: begin
                if (wrap && last_sym) begin
                    if (cur_last) begin
                        state_nxt = TAIL;
                    end else if (hold_full) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt    = TAIL;
                        underrun_set = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (wrap && last_sym) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register; frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Strobe-rate timing: impulse on the first strobe of each symbol period,
    // zero on the remaining SPS-1 strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample     <= ZERO;
            sample_cnt <= '0;
        end else if (en) begin
            if (frame_start) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample     <= (sample_cnt == '0) ? sym_val : ZERO;
                sample_cnt <= wrap ? '0 : sample_cnt + 1'b1;
            end
        end
    end

    // Symbol advance: shift out the next bit, or load the prefetched word at
    // a word boundary; the symbol index restarts at every segment end.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            cur_last  <= 1'b0;
        end else if (en) begin
            if (frame_start) begin
                bit_cnt   <= '0;
                shift_reg <= SYNC_ALIGNED;
                cur_last  <= 1'b0;
            end else if (wrap) begin
                bit_cnt <= last_sym ? '0 : bit_cnt + 1'b1;
                if (load_word) begin
                    shift_reg <= hold_data;
                    cur_last  <= hold_last;
                end else begin
                    shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // Status flags: done is a single-cycle pulse, underrun is sticky until
    // the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            underrun <= 1'b0;
        end else if (en) begin
            done <= done_set;
            if (frame_start) begin
                underrun <= 1'b0;
            end else if (underrun_set) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Self-checking bench for bpsk_tx_framer: randomized payloads and sample
// strobes, a symbol-list reference model and a per-strobe capture queue.
module tb_bpsk_tx_framer;
    import bpsk_tx_framer_pkg::*;

    localparam int          TB_SPS      = 120;
    localparam int          TB_SYNC_LEN = 32;
    localparam logic [31:0] TB_SYNC     = 32'hF3A0_5C6B;
    localparam int          TB_TAIL     = 16;
    localparam logic [13:0] P1 = 14'h1000;
    localparam logic [13:0] M1 = 14'h3000;
    localparam logic [13:0] Z0 = 14'h0000;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic               new_sample;
    logic [31:0]        s_axis_tdata;
    logic               s_axis_tlast;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic signed [13:0] sample;
    logic               busy;
    logic               done;
    logic               underrun;
    state_t             state_dbg;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [13:0] exp_q[$];
    logic [13:0] cap_q[$];
    logic [32:0] src_q[$];
    logic [31:0] pay_q[$];
    int          cap_base = 0;
    int          hs_cnt   = 0;
    int          done_cnt = 0;
    bit          pend     = 0;

    bpsk_tx_framer dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .new_sample    (new_sample),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .sample        (sample),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun),
        .state_dbg     (state_dbg)
    );

    // Clock and global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    // Sample strobe driver: mostly every cycle with occasional random gaps.
    initial begin
        new_sample = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            new_sample = ($urandom_range(0, 31) != 0);
        end
    end

    // AXI-Stream source: presents the head of src_q, pops on handshake.
    initial begin
        bit hs;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready && !rst;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) begin
                src_q.delete(0);
                hs_cnt++;
            end
            if (src_q.size() > 0) begin
                s_axis_tvalid = 1'b1;
                {s_axis_tlast, s_axis_tdata} = src_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Monitor: records the sample produced by every accepted strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (pend) cap_q.push_back(sample);
            pend = new_sample && en && busy && !rst;
            if (done) done_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: symbol list = sync bits, payload bits, tail zeros.
    function automatic void build_exp();
        logic [31:0] sw = TB_SYNC;
        logic [31:0] w;
        bit d;
        bit ref_b = 1'b0;
        exp_q.delete();
        for (int i = 0; i < TB_SYNC_LEN; i++) exp_q.push_back(sw[TB_SYNC_LEN-1-i] ? P1 : M1);
        foreach (pay_q[j]) begin
            w = pay_q[j];
            for (int b = 31; b >= 0; b--) begin
                d = w[b];
`ifdef BPSK_TX_DIFF_ENC_EN
                d = d ^ ref_b;
                ref_b = d;
`endif
                exp_q.push_back(d ? P1 : M1);
            end
        end
        for (int i = 0; i < TB_TAIL; i++) exp_q.push_back(Z0);
    endfunction

    function automatic logic [13:0] exp_sample(input int idx);
        if (idx < 0) return Z0;
        if ((idx % TB_SPS) != 0) return Z0;
        if ((idx / TB_SPS) >= exp_q.size()) return Z0;
        return exp_q[idx / TB_SPS];
    endfunction

    function automatic logic [13:0] cap_at(input int idx);
        if (cap_base + idx >= cap_q.size()) return 14'bx;
        return cap_q[cap_base + idx];
    endfunction

    task automatic push_frame();
        foreach (pay_q[i]) src_q.push_back({(i == pay_q.size() - 1), pay_q[i]});
    endtask

    task automatic start_frame();
        cap_base = cap_q.size();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < budget) begin
            step(1);
            c++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fails++;
            $display("FAIL %s done_timeout: no done after %0d cycles", name, c);
        end
    endtask

    task automatic check_stream(input string name);
        int shown = 0;
        int bad_zero = 0;
        int len = cap_q.size() - cap_base;
        n_checks++;
        if (len != exp_q.size() * TB_SPS) begin
            n_fails++;
            $display("FAIL %s length: got %0d strobes, expected %0d", name, len, exp_q.size() * TB_SPS);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (cap_at(k * TB_SPS) !== exp_q[k]) begin
                n_fails++;
                if (shown < 4) $display("FAIL %s symbol[%0d]: got %h, expected %h", name, k, cap_at(k * TB_SPS), exp_q[k]);
                shown++;
            end
        end
        for (int i = 0; i < len; i++) if ((i % TB_SPS) != 0 && cap_at(i) !== Z0) bad_zero++;
        n_checks++;
        if (bad_zero != 0) begin
            n_fails++;
            $display("FAIL %s off_impulse: %0d nonzero samples, expected 0", name, bad_zero);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        step(4);
        n_checks += 6;
        if (sample !== 14'sd0) begin n_fails++; $display("FAIL reset sample: got %h, expected 0", sample); end
        if (s_axis_tready !== 1'b0) begin n_fails++; $display("FAIL reset tready: got %b, expected 0", s_axis_tready); end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL reset busy: got %b, expected 0", busy); end
        if (done !== 1'b0) begin n_fails++; $display("FAIL reset done: got %b, expected 0", done); end
        if (underrun !== 1'b0) begin n_fails++; $display("FAIL reset underrun: got %b, expected 0", underrun); end
        if (state_dbg !== IDLE) begin n_fails++; $display("FAIL reset state: got %0d, expected IDLE", state_dbg); end
        rst = 1'b0;
        step(2);
        // start with no valid word must be ignored
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL start_no_tvalid busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single_word();
        logic [13:0] pat[4];
        int d0, h0, bad;
`ifdef BPSK_TX_DIFF_ENC_EN
        pat = '{P1, P1, M1, M1};
`else
        pat = '{P1, M1, P1, M1};
`endif
        pay_q = '{32'hA5A5_0001};
        build_exp();
        push_frame();
        step(3);
        d0 = done_cnt;
        h0 = hs_cnt;
        start_frame();
        wait_done("single", 80 * TB_SPS * 2 + 2000);
        step(5);
        check_stream("single");
        bad = 0;
        for (int i = 0; i < 4; i++) if (cap_at((TB_SYNC_LEN + i) * TB_SPS) !== pat[i]) bad++;
        n_checks += 4;
        if (bad != 0) begin n_fails++; $display("FAIL single payload_head: %0d of 4 symbols wrong", bad); end
        if (done_cnt - d0 != 1) begin n_fails++; $display("FAIL single done_count: got %0d, expected 1", done_cnt - d0); end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL single busy_after: got %b, expected 0", busy); end
        if (hs_cnt - h0 != 1) begin n_fails++; $display("FAIL single handshakes: got %0d, expected 1", hs_cnt - h0); end
    endtask

    task automatic test_four_words();
        int h0;
        pay_q.delete();
        for (int i = 0; i < 4; i++) pay_q.push_back($urandom);
        build_exp();
        push_frame();
        step(3);
        h0 = hs_cnt;
        start_frame();
        // a start request mid-frame must have no effect
        step(($urandom_range(100, 3000)));
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("four", 176 * TB_SPS * 2 + 2000);
        step(3);
        check_stream("four");
        n_checks += 2;
        if (hs_cnt - h0 != 4) begin n_fails++; $display("FAIL four handshakes: got %0d, expected 4", hs_cnt - h0); end
        if (underrun !== 1'b0) begin n_fails++; $display("FAIL four underrun: got %b, expected 0", underrun); end
    endtask

    task automatic test_underrun();
        int h0, c;
        logic [31:0] w2;
        pay_q = '{$urandom};
        w2 = $urandom;
        src_q.push_back({1'b0, pay_q[0]});
        build_exp();
        step(3);
        h0 = hs_cnt;
        start_frame();
        c = 0;
        while (underrun !== 1'b1 && c < 70 * TB_SPS * 2) begin
            step(1);
            c++;
        end
        n_checks++;
        if (underrun !== 1'b1) begin n_fails++; $display("FAIL underrun flag: got %b, expected 1", underrun); end
        src_q.push_back({1'b1, w2});
        wait_done("underrun", 20 * TB_SPS * 2 + 2000);
        step(3);
        check_stream("underrun");
        n_checks += 2;
        if (underrun !== 1'b1) begin n_fails++; $display("FAIL underrun sticky: got %b, expected 1", underrun); end
        if (hs_cnt - h0 != 1) begin n_fails++; $display("FAIL underrun handshakes: got %0d, expected 1", hs_cnt - h0); end
        src_q.delete();
        step(3);
    endtask

    task automatic test_reset_mid_frame();
        int c, d0;
        pay_q = '{$urandom, $urandom};
        push_frame();
        step(3);
        start_frame();
        step(2);
        n_checks++;
        if (underrun !== 1'b0) begin n_fails++; $display("FAIL restart underrun_clear: got %b, expected 0", underrun); end
        c = 0;
        while ((cap_q.size() - cap_base) < (TB_SYNC_LEN + 10) * TB_SPS + 1 && c < 60 * TB_SPS * 2) begin
            step(1);
            c++;
        end
        n_checks++;
        if ((cap_q.size() - cap_base) < (TB_SYNC_LEN + 10) * TB_SPS + 1) begin
            n_fails++;
            $display("FAIL midreset reach_symbol10: got %0d strobes", cap_q.size() - cap_base);
        end
        d0 = done_cnt;
        rst = 1'b1;
        step(1);
        n_checks += 4;
        if (sample !== 14'sd0) begin n_fails++; $display("FAIL midreset sample: got %h, expected 0", sample); end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL midreset busy: got %b, expected 0", busy); end
        if (s_axis_tready !== 1'b0) begin n_fails++; $display("FAIL midreset tready: got %b, expected 0", s_axis_tready); end
        if (state_dbg !== IDLE) begin n_fails++; $display("FAIL midreset state: got %0d, expected IDLE", state_dbg); end
        rst = 1'b0;
        src_q.delete();
        step(300);
        n_checks++;
        if (done_cnt != d0) begin n_fails++; $display("FAIL midreset no_done: got %0d pulses, expected 0", done_cnt - d0); end
    endtask

    task automatic test_en_freeze();
        int c, fsize, bad_s, bad_r, bad_b, bad_n;
        pay_q = '{$urandom};
        build_exp();
        push_frame();
        step(3);
        start_frame();
        c = 0;
        while ((cap_q.size() - cap_base) < 10 * TB_SPS + 1 && c < 20 * TB_SPS * 2) begin
            step(1);
            c++;
        end
        en = 1'b0;
        step(1);
        fsize = cap_q.size();
        bad_s = 0; bad_r = 0; bad_b = 0; bad_n = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (sample !== exp_sample(fsize - 1 - cap_base)) bad_s++;
            if (s_axis_tready !== 1'b0) bad_r++;
            if (busy !== 1'b1 || done !== 1'b0) bad_b++;
            if (cap_q.size() != fsize) bad_n++;
        end
        n_checks += 4;
        if (bad_s != 0) begin n_fails++; $display("FAIL freeze sample_hold: %0d cycles differ from %h", bad_s, exp_sample(fsize - 1 - cap_base)); end
        if (bad_r != 0) begin n_fails++; $display("FAIL freeze tready: %0d cycles high, expected 0", bad_r); end
        if (bad_b != 0) begin n_fails++; $display("FAIL freeze busy_done: %0d cycles wrong, expected busy=1 done=0", bad_b); end
        if (bad_n != 0) begin n_fails++; $display("FAIL freeze strobes: %0d cycles advanced, expected 0", bad_n); end
        en = 1'b1;
        wait_done("freeze", 80 * TB_SPS * 2 + 2000);
        step(3);
        check_stream("freeze");
    endtask

    task automatic test_diff_patterns();
        int bad0, bad1;
        logic [13:0] e1;
        pay_q = '{32'h0000_0000, 32'hFFFF_FFFF};
        build_exp();
        push_frame();
        step(3);
        start_frame();
        wait_done("pattern", 112 * TB_SPS * 2 + 2000);
        step(3);
        check_stream("pattern");
        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < 32; i++) begin
            if (cap_at((TB_SYNC_LEN + i) * TB_SPS) !== M1) bad0++;
`ifdef BPSK_TX_DIFF_ENC_EN
            e1 = (i % 2 == 0) ? P1 : M1;
`else
            e1 = P1;
`endif
            if (cap_at((TB_SYNC_LEN + 32 + i) * TB_SPS) !== e1) bad1++;
        end
        n_checks += 2;
        if (bad0 != 0) begin n_fails++; $display("FAIL pattern zeros_word: %0d symbols not -1", bad0); end
        if (bad1 != 0) begin n_fails++; $display("FAIL pattern ones_word: %0d symbols wrong", bad1); end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        test_reset();
        test_single_word();
        test_four_words();
        test_underrun();
        test_reset_mid_frame();
        test_en_freeze();
        test_diff_patterns();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
